// File: rtl/nanorisc_pkg.sv
// Shared NanoRISC definitions: default widths, opcode encodings and the
// instruction-fetch state encoding. IFETCH_TIMEOUT_EN adds the ERR state.
package nanorisc_pkg;

  localparam int DEF_PC_W    = 8;
  localparam int DEF_INSTR_W = 8;
  localparam int DEF_TIMEOUT = 15;

  localparam logic [2:0] OP_SUM  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_LW   = 3'b100;
  localparam logic [2:0] OP_SW   = 3'b101;
  localparam logic [2:0] OP_BNE  = 3'b110;
  localparam logic [2:0] OP_SEND = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_VALID,
`ifdef IFETCH_TIMEOUT_EN
    ST_HALT,
    ST_ERR
`else
    ST_HALT
`endif
  } ifetch_state_e;

endpackage

// File: rtl/ifetch_unit_if.sv
// Bundle of the fetch unit's memory, control-unit and status signals.
// master = fetch unit side, slave = memory/control-unit side.
interface ifetch_unit_if
  import nanorisc_pkg::*;
#(
  parameter int PC_W    = DEF_PC_W,
  parameter int INSTR_W = DEF_INSTR_W
) ();

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] instr;
  logic [2:0]         opcode;
  logic               instr_valid;
  logic               exec_done;
  logic               pc_write;
  logic               branch_taken;
  logic [PC_W-1:0]    branch_target;
  logic [PC_W-1:0]    pc;
  logic               halted;
  logic               fetch_err;

  modport master (
    output imem_req, imem_addr, instr, opcode, instr_valid, pc, halted, fetch_err,
    input  imem_ack, imem_rdata, exec_done, pc_write, branch_taken, branch_target
  );

  modport slave (
    input  imem_req, imem_addr, instr, opcode, instr_valid, pc, halted, fetch_err,
    output imem_ack, imem_rdata, exec_done, pc_write, branch_taken, branch_target
  );

endinterface

// File: rtl/ifetch_pc.sv
// Program counter: holds, increments (wrapping) or loads a branch target.
module ifetch_pc #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            sel_branch,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_q, pc_d;

  // Next PC: branch target or pc+1 (modulo 2^PC_W) when loading, else hold.
  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = sel_branch ? target : pc_q + 1'b1;
    end
  end

  // PC register, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking (<=) in clocked blocks so every flop samples pre-edge values.
    if (!rst_n) pc_q <= '0;
    else        pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: fetches the word at pc, presents it until the
// downstream finishes, then advances (pc+1 or branch) or halts.
// Optional fetch watchdog enabled by macro IFETCH_TIMEOUT_EN.
module ifetch_unit
  import nanorisc_pkg::*;
#(
  parameter int PC_W    = DEF_PC_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [2:0]         opcode,
  output logic               instr_valid,
  input  logic               exec_done,
  input  logic               pc_write,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic [PC_W-1:0]    pc,
  output logic               halted,
  output logic               fetch_err
);

  ifetch_state_e      state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               pc_load;

  // PC only advances on an accepted exec_done with pc_write=1, so a halt
  // request always wins over a simultaneous branch.
  ifetch_pc #(.PC_W(PC_W)) u_pc (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (pc_load),
    .sel_branch (branch_taken),
    .target     (branch_target),
    .pc         (pc)
  );

`ifdef IFETCH_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            wdog_expire;

  // Watchdog: counts unacknowledged FETCH cycles, zero everywhere else so
  // each entry into FETCH starts from a clean count.
  always_comb begin
    wdog_d      = '0;
    wdog_expire = 1'b0;
    if (state_q == ST_FETCH && !imem_ack) begin
      wdog_d      = wdog_q + 1'b1;
      wdog_expire = (wdog_q == WD_W'(TIMEOUT - 1));
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wdog_q <= '0;
    else        wdog_q <= wdog_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; imem_ack outside FETCH and exec_done outside VALID fall through.
  always_comb begin
    // NOTE: default every always_comb output first so no path infers a latch.
    state_d = state_q;
    pc_load = 1'b0;
    case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack) state_d = ST_VALID;
`ifdef IFETCH_TIMEOUT_EN
        else if (wdog_expire) state_d = ST_ERR;
`endif
      end
      ST_VALID: begin
        if (exec_done) begin
          if (!pc_write) begin
            state_d = ST_HALT;
          end else begin
            state_d = ST_FETCH;
            pc_load = 1'b1;
          end
        end
      end
      default:  state_d = state_q;
    endcase
  end

  // Instruction register captures the word only on an acknowledged fetch.
  always_comb begin
    instr_d = instr_q;
    if (state_q == ST_FETCH && imem_ack) instr_d = imem_rdata;
  end

  // Instruction register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) instr_q <= '0;
    else        instr_q <= instr_d;
  end

  // Moore outputs decoded from state, so reset drops imem_req immediately.
  always_comb begin
    imem_req    = (state_q == ST_FETCH);
    instr_valid = (state_q == ST_VALID);
    halted      = (state_q == ST_HALT);
`ifdef IFETCH_TIMEOUT_EN
    fetch_err   = (state_q == ST_ERR);
`else
    fetch_err   = 1'b0;
`endif
  end

  assign imem_addr = pc;
  assign instr     = instr_q;
  assign opcode    = instr_q[INSTR_W-1 -: 3];

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have parameters, one per line:
- PC_W, 8, PC and instruction-address width.
- INSTR_W, 8, instruction width; opcode = instr[INSTR_W-1 -: 3].
- TIMEOUT, 15, fetch-watchdog cycle limit; used only with IFETCH_TIMEOUT_EN.

REQ-002 SHALL have ports, one per line:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request, held until acknowledged.
- imem_addr  out  PC_W  fetch address, equal to pc.
- imem_ack  in  1  memory accepts the request and returns data in the same cycle.
- imem_rdata  in  INSTR_W  instruction word, valid while imem_ack is high.
- instr  out  INSTR_W  registered instruction.
- opcode  out  3  top 3 bits of instr, feeding the control unit.
- instr_valid  out  1  instr/opcode hold a valid instruction.
- exec_done  in  1  downstream has finished the current instruction (1-cycle pulse).
- pc_write  in  1  control-unit PCWrite; 0 means halt.
- branch_taken  in  1  bne resolved taken; sampled with exec_done.
- branch_target  in  PC_W  next PC when branch_taken is high.
- pc  out  PC_W  current program counter.
- halted  out  1  sticky halt indicator.
- fetch_err  out  1  watchdog error; present only with IFETCH_TIMEOUT_EN, otherwise tied 0.

Function
REQ-003 SHALL implement FSM states: IDLE, FETCH, VALID, HALT, and ERR (ERR only with IFETCH_TIMEOUT_EN).
REQ-004 IDLE SHALL move to FETCH unconditionally on the first clock edge after reset release.
REQ-005 In FETCH: imem_req=1, imem_addr=pc. On imem_ack=1, instr<=imem_rdata and the FSM moves to VALID (1-cycle request-to-data latency minimum).
REQ-006 In VALID: instr_valid=1 and imem_req=0. instr and opcode SHALL stay stable until exec_done.
REQ-007 When exec_done=1 in VALID:
- if pc_write=0, go to HALT with pc unchanged;
- else pc <= branch_taken ? branch_target : pc+1, then go to FETCH.
REQ-008 pc+1 SHALL wrap modulo 2^PC_W (e.g. 8'hFF -> 8'h00), with no flag.
REQ-009 When pc_write=0 and branch_taken=1 arrive together, halt SHALL take priority and branch_target is ignored.
REQ-010 HALT SHALL be absorbing until reset: halted=1, instr_valid=0, imem_req=0, and pc holds the address of the halt instruction.
REQ-011 imem_ack outside FETCH and exec_done outside VALID SHALL be ignored with no state change.
REQ-012 instr_valid SHALL deassert in the cycle after exec_done is accepted; there are no back-to-back valid cycles without a fetch.

Reset
REQ-013 When rst_n=0, all state SHALL clear asynchronously: state=IDLE, pc=0, instr=0, instr_valid=0, imem_req=0, halted=0, fetch_err=0, watchdog count=0.
REQ-014 Reset asserted mid-FETCH SHALL drop imem_req immediately, and a late imem_ack is ignored.

Configuration
REQ-015 Macro IFETCH_TIMEOUT_EN, when defined, SHALL add the fetch watchdog:
- count FETCH cycles without imem_ack;
- if the count reaches TIMEOUT, go to ERR: fetch_err=1, imem_req=0, instr_valid=0;
- ERR is absorbing until reset;
- the counter clears on entry to FETCH.
REQ-016 Without IFETCH_TIMEOUT_EN, the block SHALL have no counter and no ERR state, fetch_err SHALL be constant 0, and FETCH SHALL wait indefinitely.

Structure
REQ-017 Shared package nanorisc_pkg SHALL hold:
- opcode constants OP_SUM..OP_SEND (3'b000..3'b111);
- the ifetch state enum;
- default widths.
REQ-018 The PC register with increment/branch-select logic SHALL be a sub-module ifetch_pc (inputs: load, sel_branch, target; output: pc).

Verification
REQ-019 Reset release, imem_ack on the 2nd FETCH cycle with rdata=8'h25 -> instr=8'h25, opcode=3'b001, instr_valid=1, pc=0.
REQ-020 exec_done with pc_write=1, branch_taken=0 at pc=8'hFF -> next imem_addr=8'h00.
REQ-021 exec_done with branch_taken=1, target=8'h10 -> imem_addr=8'h10 in the next FETCH.
REQ-022 exec_done with pc_write=0 and branch_taken=1 at pc=8'h07 -> halted=1, pc stays 8'h07, no further imem_req for 20 cycles.
REQ-023 rst_n pulsed low mid-FETCH -> imem_req=0 asynchronously; after release, refetch from pc=0.
REQ-024 With IFETCH_TIMEOUT_EN and TIMEOUT=15, no imem_ack -> fetch_err=1 after 15 FETCH cycles, imem_req=0, and a later ack is ignored.
